// File: rtl/wt_mem_arbiter.sv
// Shares the memory request channel between the I$ and D$ of the write-through cache
// subsystem. It grants round-robin, tracks outstanding IDs, and routes returns to their owner.
module wt_mem_arbiter #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned ReqWidth  = 128,
  parameter int unsigned RtrnWidth = 256,
  parameter int unsigned MaxOut    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ic_req_i,
  output logic                 ic_ack_o,
  input  logic [IdWidth-1:0]   ic_tid_i,
  input  logic [ReqWidth-1:0]  ic_data_i,
  input  logic                 dc_req_i,
  output logic                 dc_ack_o,
  input  logic [IdWidth-1:0]   dc_tid_i,
  input  logic [ReqWidth-1:0]  dc_data_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [IdWidth-1:0]   mem_tid_o,
  output logic [ReqWidth-1:0]  mem_data_o,
  input  logic                 rtrn_valid_i,
  input  logic [IdWidth-1:0]   rtrn_tid_i,
  input  logic [RtrnWidth-1:0] rtrn_data_i,
  output logic                 ic_rtrn_vld_o,
  output logic                 dc_rtrn_vld_o,
  output logic [RtrnWidth-1:0] rtrn_data_o,
  output logic [IdWidth-1:0]   rtrn_tid_o,
  output logic                 err_o
);

  localparam int unsigned NumIds   = 2**IdWidth;
  localparam int unsigned CntWidth = $clog2(MaxOut + 1);

  typedef enum logic {
    FAV_IC = 1'b0,
    FAV_DC = 1'b1
  } rr_e;

  rr_e                 rr_q, rr_d;
  logic                mem_valid_q;
  logic [IdWidth-1:0]  mem_tid_q;
  logic [ReqWidth-1:0] mem_data_q;
  logic                err_q;
  logic [NumIds-1:0]   busy_q, busy_d;
  logic [NumIds-1:0]   owner_q;  // 1 = D$ owns the ID
  logic [CntWidth-1:0] ic_cnt_q, ic_cnt_d;
  logic [CntWidth-1:0] dc_cnt_q, dc_cnt_d;

  logic                out_free, ic_elig, dc_elig, ic_gnt, dc_gnt, any_gnt;
  logic [IdWidth-1:0]  gnt_tid;
  logic [ReqWidth-1:0] gnt_data;
  logic                rtrn_hit, ic_rtrn, dc_rtrn;

  always_comb begin
    out_free = !mem_valid_q || mem_ready_i;
    ic_elig  = ic_req_i && !busy_q[ic_tid_i] && (ic_cnt_q < CntWidth'(MaxOut));
    dc_elig  = dc_req_i && !busy_q[dc_tid_i] && (dc_cnt_q < CntWidth'(MaxOut));
    ic_gnt   = 1'b0;
    dc_gnt   = 1'b0;
    if (rst_ni && out_free) begin
      if (ic_elig && dc_elig) begin
        ic_gnt = (rr_q == FAV_IC);
        dc_gnt = (rr_q == FAV_DC);
      end else begin
        ic_gnt = ic_elig;
        dc_gnt = dc_elig;
      end
    end
    any_gnt  = ic_gnt || dc_gnt;
    gnt_tid  = dc_gnt ? dc_tid_i  : ic_tid_i;
    gnt_data = dc_gnt ? dc_data_i : ic_data_i;

    rr_d = rr_q;
    if (ic_gnt) begin
      rr_d = FAV_DC;
    end else if (dc_gnt) begin
      rr_d = FAV_IC;
    end
  end

  always_comb begin
    rtrn_hit = rtrn_valid_i && busy_q[rtrn_tid_i];
    ic_rtrn  = rtrn_hit && !owner_q[rtrn_tid_i];
    dc_rtrn  = rtrn_hit &&  owner_q[rtrn_tid_i];

    // A returning ID is busy and a granted ID is not, so the two updates never collide.
    busy_d = busy_q;
    if (rtrn_hit) busy_d[rtrn_tid_i] = 1'b0;
    if (any_gnt)  busy_d[gnt_tid]    = 1'b1;

    ic_cnt_d = ic_cnt_q;
    case ({ic_gnt, ic_rtrn})
      2'b10:   ic_cnt_d = ic_cnt_q + CntWidth'(1);
      2'b01:   ic_cnt_d = ic_cnt_q - CntWidth'(1);
      default: ic_cnt_d = ic_cnt_q;
    endcase
    dc_cnt_d = dc_cnt_q;
    case ({dc_gnt, dc_rtrn})
      2'b10:   dc_cnt_d = dc_cnt_q + CntWidth'(1);
      2'b01:   dc_cnt_d = dc_cnt_q - CntWidth'(1);
      default: dc_cnt_d = dc_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q        <= FAV_IC;
      mem_valid_q <= 1'b0;
      mem_tid_q   <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= '0;
      owner_q     <= '0;
      ic_cnt_q    <= '0;
      dc_cnt_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      ic_cnt_q <= ic_cnt_d;
      dc_cnt_q <= dc_cnt_d;
      if (any_gnt) begin
        mem_valid_q      <= 1'b1;
        mem_tid_q        <= gnt_tid;
        mem_data_q       <= gnt_data;
        owner_q[gnt_tid] <= dc_gnt;
      end else if (mem_ready_i) begin
        mem_valid_q <= 1'b0;
      end
      if (rtrn_valid_i && !busy_q[rtrn_tid_i]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ic_ack_o      = ic_gnt;
  assign dc_ack_o      = dc_gnt;
  assign mem_valid_o   = mem_valid_q;
  assign mem_tid_o     = mem_tid_q;
  assign mem_data_o    = mem_data_q;
  assign ic_rtrn_vld_o = ic_rtrn;
  assign dc_rtrn_vld_o = dc_rtrn;
  assign rtrn_data_o   = rtrn_data_i;
  assign rtrn_tid_o    = rtrn_tid_i;
  assign err_o         = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed bench for wt_mem_arbiter: arbitration order, hold, ID tracking, throttling, errors.
module tb_wt_mem_arbiter;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned ReqWidth  = 128;
  localparam int unsigned RtrnWidth = 256;
  localparam int unsigned MaxOut    = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 ic_req_i, dc_req_i, ic_ack_o, dc_ack_o;
  logic [IdWidth-1:0]   ic_tid_i, dc_tid_i;
  logic [ReqWidth-1:0]  ic_data_i, dc_data_i;
  logic                 mem_valid_o, mem_ready_i;
  logic [IdWidth-1:0]   mem_tid_o;
  logic [ReqWidth-1:0]  mem_data_o;
  logic                 rtrn_valid_i;
  logic [IdWidth-1:0]   rtrn_tid_i;
  logic [RtrnWidth-1:0] rtrn_data_i;
  logic                 ic_rtrn_vld_o, dc_rtrn_vld_o;
  logic [RtrnWidth-1:0] rtrn_data_o;
  logic [IdWidth-1:0]   rtrn_tid_o;
  logic                 err_o;

  int unsigned vec  = 0;
  int unsigned miss = 0;

  wt_mem_arbiter #(
    .IdWidth  (IdWidth),
    .ReqWidth (ReqWidth),
    .RtrnWidth(RtrnWidth),
    .MaxOut   (MaxOut)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ic_req_i     (ic_req_i),
    .ic_ack_o     (ic_ack_o),
    .ic_tid_i     (ic_tid_i),
    .ic_data_i    (ic_data_i),
    .dc_req_i     (dc_req_i),
    .dc_ack_o     (dc_ack_o),
    .dc_tid_i     (dc_tid_i),
    .dc_data_i    (dc_data_i),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_tid_o    (mem_tid_o),
    .mem_data_o   (mem_data_o),
    .rtrn_valid_i (rtrn_valid_i),
    .rtrn_tid_i   (rtrn_tid_i),
    .rtrn_data_i  (rtrn_data_i),
    .ic_rtrn_vld_o(ic_rtrn_vld_o),
    .dc_rtrn_vld_o(dc_rtrn_vld_o),
    .rtrn_data_o  (rtrn_data_o),
    .rtrn_tid_o   (rtrn_tid_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Registered outputs are checked right after tick; combinational ones #1 after driving.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_i = 1'b0; ic_tid_i = '0; ic_data_i = '0;
    dc_req_i = 1'b0; dc_tid_i = '0; dc_data_i = '0;
    mem_ready_i = 1'b1;
    rtrn_valid_i = 1'b0; rtrn_tid_i = '0; rtrn_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    ic_req_i = 1'b1; ic_tid_i = 4'd1; dc_req_i = 1'b1; dc_tid_i = 4'd2;
    #1;
    vec++; if (ic_ack_o !== 1'b0) begin miss++; $display("FAIL reset_ic_ack: got %b want 0", ic_ack_o); end
    vec++; if (dc_ack_o !== 1'b0) begin miss++; $display("FAIL reset_dc_ack: got %b want 0", dc_ack_o); end
    tick();
    tick();
    vec++; if (mem_valid_o !== 1'b0) begin miss++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
    vec++; if (mem_tid_o !== 4'd0) begin miss++; $display("FAIL reset_mem_tid: got %0d want 0", mem_tid_o); end
    vec++; if (mem_data_o !== '0) begin miss++; $display("FAIL reset_mem_data: got %h want 0", mem_data_o); end
    vec++; if (err_o !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", err_o); end
    // Grant I$ tid 3, then reset before its return: the return must be treated as unexpected.
    idle_inputs();
    rst_ni = 1'b1;
    ic_req_i = 1'b1; ic_tid_i = 4'd3;
    #1;
    vec++; if (ic_ack_o !== 1'b1) begin miss++; $display("FAIL midrst_grant: got %b want 1", ic_ack_o); end
    tick();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd3;
    #1;
    vec++; if ({ic_rtrn_vld_o, dc_rtrn_vld_o} !== 2'b00) begin miss++; $display("FAIL midrst_rtrn_vld: got %b want 00", {ic_rtrn_vld_o, dc_rtrn_vld_o}); end
    tick();
    rtrn_valid_i = 1'b0;
    vec++; if (err_o !== 1'b1) begin miss++; $display("FAIL midrst_err: got %b want 1", err_o); end
  endtask

  task automatic test_single();
    do_reset();
    ic_req_i = 1'b1; ic_tid_i = 4'd3; ic_data_i = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    #1;
    vec++; if (ic_ack_o !== 1'b1) begin miss++; $display("FAIL single_ic_ack: got %b want 1", ic_ack_o); end
    vec++; if (dc_ack_o !== 1'b0) begin miss++; $display("FAIL single_dc_ack: got %b want 0", dc_ack_o); end
    vec++; if (mem_valid_o !== 1'b0) begin miss++; $display("FAIL single_valid_n: got %b want 0", mem_valid_o); end
    tick();
    ic_req_i = 1'b0;
    vec++; if (mem_valid_o !== 1'b1) begin miss++; $display("FAIL single_valid_n1: got %b want 1", mem_valid_o); end
    vec++; if (mem_tid_o !== 4'd3) begin miss++; $display("FAIL single_tid: got %0d want 3", mem_tid_o); end
    vec++; if (mem_data_o !== 128'hA5A5_0000_1111_2222_3333_4444_5555_6666) begin miss++; $display("FAIL single_data: got %h want a5a5...6666", mem_data_o); end
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd3; rtrn_data_i = 256'hDEAD_BEEF;
    #1;
    vec++; if ({ic_rtrn_vld_o, dc_rtrn_vld_o} !== 2'b10) begin miss++; $display("FAIL single_route: got %b want 10", {ic_rtrn_vld_o, dc_rtrn_vld_o}); end
    vec++; if (rtrn_data_o !== 256'hDEAD_BEEF) begin miss++; $display("FAIL single_rdata: got %h want deadbeef", rtrn_data_o); end
    vec++; if (rtrn_tid_o !== 4'd3) begin miss++; $display("FAIL single_rtid: got %0d want 3", rtrn_tid_o); end
    tick();
    rtrn_valid_i = 1'b0;
    vec++; if (mem_valid_o !== 1'b0) begin miss++; $display("FAIL single_drain: got %b want 0", mem_valid_o); end
    vec++; if (err_o !== 1'b0) begin miss++; $display("FAIL single_err: got %b want 0", err_o); end
  endtask

  task automatic test_round_robin();
    logic [IdWidth-1:0] ic_t, dc_t, exp_tid;
    logic exp_ic;
    do_reset();
    ic_t = 4'd0;
    dc_t = 4'd8;
    for (int k = 0; k < 6; k++) begin
      ic_req_i = 1'b1; ic_tid_i = ic_t; ic_data_i = {124'h0, ic_t};
      dc_req_i = 1'b1; dc_tid_i = dc_t; dc_data_i = {124'h1, dc_t};
      #1;
      exp_ic  = (k % 2 == 0);
      exp_tid = exp_ic ? ic_t : dc_t;
      vec++; if ({ic_ack_o, dc_ack_o} !== {exp_ic, !exp_ic}) begin miss++; $display("FAIL rr_ack[%0d]: got %b want %b", k, {ic_ack_o, dc_ack_o}, {exp_ic, !exp_ic}); end
      if (exp_ic) ic_t = ic_t + 4'd1;
      else        dc_t = dc_t + 4'd1;
      tick();
      vec++; if (mem_valid_o !== 1'b1) begin miss++; $display("FAIL rr_valid[%0d]: got %b want 1", k, mem_valid_o); end
      vec++; if (mem_tid_o !== exp_tid) begin miss++; $display("FAIL rr_tid[%0d]: got %0d want %0d", k, mem_tid_o, exp_tid); end
    end
    idle_inputs();
    tick();
    vec++; if (mem_valid_o !== 1'b0) begin miss++; $display("FAIL rr_drain: got %b want 0", mem_valid_o); end
  endtask

  task automatic test_hold();
    do_reset();
    mem_ready_i = 1'b0;
    dc_req_i = 1'b1; dc_tid_i = 4'd4; dc_data_i = 128'hD1;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL hold_first_ack: got %b want 1", dc_ack_o); end
    tick();
    dc_tid_i = 4'd5; dc_data_i = 128'hD2;
    for (int k = 0; k < 5; k++) begin
      #1;
      vec++; if ({ic_ack_o, dc_ack_o} !== 2'b00) begin miss++; $display("FAIL hold_ack[%0d]: got %b want 00", k, {ic_ack_o, dc_ack_o}); end
      vec++; if ({mem_valid_o, mem_tid_o, mem_data_o} !== {1'b1, 4'd4, 128'hD1}) begin miss++; $display("FAIL hold_out[%0d]: got v=%b tid=%0d data=%h want v=1 tid=4 data=d1", k, mem_valid_o, mem_tid_o, mem_data_o); end
      tick();
    end
    mem_ready_i = 1'b1;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL hold_release_ack: got %b want 1", dc_ack_o); end
    tick();
    dc_req_i = 1'b0;
    vec++; if ({mem_valid_o, mem_tid_o, mem_data_o} !== {1'b1, 4'd5, 128'hD2}) begin miss++; $display("FAIL hold_b2b: got v=%b tid=%0d data=%h want v=1 tid=5 data=d2", mem_valid_o, mem_tid_o, mem_data_o); end
  endtask

  task automatic test_maxout();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      dc_req_i = 1'b1; dc_tid_i = 4'(k);
      #1;
      vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL max_fill_ack[%0d]: got %b want 1", k, dc_ack_o); end
      tick();
    end
    dc_tid_i = 4'd8;
    ic_req_i = 1'b1; ic_tid_i = 4'd12;
    #1;
    vec++; if ({ic_ack_o, dc_ack_o} !== 2'b10) begin miss++; $display("FAIL max_stall0: got %b want 10", {ic_ack_o, dc_ack_o}); end
    tick();
    ic_tid_i = 4'd13;
    #1;
    vec++; if ({ic_ack_o, dc_ack_o} !== 2'b10) begin miss++; $display("FAIL max_stall1: got %b want 10", {ic_ack_o, dc_ack_o}); end
    tick();
    ic_req_i = 1'b0;
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd2;
    #1;
    vec++; if ({ic_rtrn_vld_o, dc_rtrn_vld_o} !== 2'b01) begin miss++; $display("FAIL max_route: got %b want 01", {ic_rtrn_vld_o, dc_rtrn_vld_o}); end
    vec++; if (dc_ack_o !== 1'b0) begin miss++; $display("FAIL max_same_cycle: got %b want 0", dc_ack_o); end
    tick();
    rtrn_valid_i = 1'b0;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL max_resume: got %b want 1", dc_ack_o); end
    tick();
    dc_req_i = 1'b0;
  endtask

  task automatic test_unexpected();
    do_reset();
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd5;
    #1;
    vec++; if ({ic_rtrn_vld_o, dc_rtrn_vld_o} !== 2'b00) begin miss++; $display("FAIL unexp_route: got %b want 00", {ic_rtrn_vld_o, dc_rtrn_vld_o}); end
    tick();
    rtrn_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vec++; if (err_o !== 1'b1) begin miss++; $display("FAIL unexp_sticky[%0d]: got %b want 1", k, err_o); end
      tick();
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    vec++; if (err_o !== 1'b0) begin miss++; $display("FAIL unexp_clear: got %b want 0", err_o); end
  endtask

  task automatic test_rerequest();
    do_reset();
    dc_req_i = 1'b1; dc_tid_i = 4'd2;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL rereq_first: got %b want 1", dc_ack_o); end
    tick();
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd2;
    #1;
    vec++; if ({dc_rtrn_vld_o, dc_ack_o} !== 2'b10) begin miss++; $display("FAIL rereq_same_cycle: got rtrn,ack=%b want 10", {dc_rtrn_vld_o, dc_ack_o}); end
    tick();
    rtrn_valid_i = 1'b0;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL rereq_next: got %b want 1", dc_ack_o); end
    tick();
    dc_req_i = 1'b0;
    vec++; if (dut.dc_cnt_q !== 4'd1) begin miss++; $display("FAIL rereq_cnt: got %0d want 1", dut.dc_cnt_q); end
    // Grant tid 3 while tid 2 returns: net counter change is zero.
    dc_req_i = 1'b1; dc_tid_i = 4'd3;
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd2;
    #1;
    vec++; if ({dc_rtrn_vld_o, dc_ack_o} !== 2'b11) begin miss++; $display("FAIL swap_cycle: got rtrn,ack=%b want 11", {dc_rtrn_vld_o, dc_ack_o}); end
    tick();
    idle_inputs();
    vec++; if (dut.dc_cnt_q !== 4'd1) begin miss++; $display("FAIL swap_cnt: got %0d want 1", dut.dc_cnt_q); end
  endtask

  task automatic test_same_tid();
    do_reset();
    ic_req_i = 1'b1; ic_tid_i = 4'd6;
    dc_req_i = 1'b1; dc_tid_i = 4'd6;
    #1;
    vec++; if ({ic_ack_o, dc_ack_o} !== 2'b10) begin miss++; $display("FAIL tid_clash_win: got %b want 10", {ic_ack_o, dc_ack_o}); end
    tick();
    ic_req_i = 1'b0;
    #1;
    vec++; if (dc_ack_o !== 1'b0) begin miss++; $display("FAIL tid_clash_wait: got %b want 0", dc_ack_o); end
    tick();
    rtrn_valid_i = 1'b1; rtrn_tid_i = 4'd6;
    #1;
    vec++; if ({ic_rtrn_vld_o, dc_rtrn_vld_o, dc_ack_o} !== 3'b100) begin miss++; $display("FAIL tid_clash_rtrn: got %b want 100", {ic_rtrn_vld_o, dc_rtrn_vld_o, dc_ack_o}); end
    tick();
    rtrn_valid_i = 1'b0;
    #1;
    vec++; if (dc_ack_o !== 1'b1) begin miss++; $display("FAIL tid_clash_late: got %b want 1", dc_ack_o); end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_maxout();
    test_unexpected();
    test_rerequest();
    test_same_tid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
